// File: rtl/branch_predictor_pkg.sv
// Shared widths and constants for the branch target buffer.
// Address/register widths and the default table size live here for all BTB files.
package branch_predictor_pkg;

  localparam int InstAddrBus  = 32;
  localparam int RegBus       = 32;
  localparam int BtbIndexBits = 6;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef logic [InstAddrBus-1:0] addr_t;
  typedef logic [RegBus-1:0]      stat_t;
  typedef logic [1:0]             ctr_t;

  // Reset leaves counters weakly not-taken; a fresh allocation starts weakly taken.
  localparam ctr_t CtrReset = 2'd1;
  localparam ctr_t CtrAlloc = 2'd2;
  localparam ctr_t CtrMax   = 2'd3;
  localparam ctr_t CtrMin   = 2'd0;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, EX-resolution and statistics signals of the branch predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  addr_t query_pc;
  logic  predict_result;
  addr_t npc;
  logic  predict_update;
  logic  actual_result;
  addr_t branch_pc;
  addr_t branch_npc;
  logic  predict_error;
  stat_t stat_updates;
  stat_t stat_mispredicts;

  modport master (
    output query_pc, predict_update, actual_result, branch_pc, branch_npc, predict_error,
    input  predict_result, npc, stat_updates, stat_mispredicts
  );

  modport slave (
    input  query_pc, predict_update, actual_result, branch_pc, branch_npc, predict_error,
    output predict_result, npc, stat_updates, stat_mispredicts
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating direction counter: next value from old value and inc/dec.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic inc_i,
  input  logic dec_i,
  output ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i && ctr_i != CtrMax) begin
      ctr_o = ctr_i + 2'd1;
    end else if (dec_i && ctr_i != CtrMin) begin
      ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and wrap-around performance counters.
// Lookup is combinational; training from EX lands on the clock edge with no bypass.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BtbIndexBits
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  branch_predictor_if.slave bp
);

  localparam int Entries = 1 << INDEX_BITS;
  localparam int TagW    = InstAddrBus - INDEX_BITS - 2;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TagW-1:0]       tag_t;

  logic  valid_q  [Entries];
  tag_t  tag_q    [Entries];
  addr_t target_q [Entries];
  ctr_t  ctr_q    [Entries];

  stat_t stat_upd_q, stat_upd_d;
  stat_t stat_mis_q, stat_mis_d;

  idx_t q_idx;
  tag_t q_tag;
  logic q_hit;
  logic q_taken;

  assign q_idx   = bp.query_pc[INDEX_BITS+1:2];
  assign q_tag   = bp.query_pc[InstAddrBus-1:INDEX_BITS+2];
  assign q_hit   = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
  assign q_taken = q_hit && ctr_q[q_idx][1];

  assign bp.predict_result = q_taken;
  assign bp.npc            = q_taken ? target_q[q_idx] : bp.query_pc + 32'd4;

  idx_t u_idx;
  tag_t u_tag;
  logic u_hit;
  logic upd_en;
  ctr_t u_ctr_next;

  assign u_idx  = bp.branch_pc[INDEX_BITS+1:2];
  assign u_tag  = bp.branch_pc[InstAddrBus-1:INDEX_BITS+2];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_en = rdy_in && bp.predict_update;

  sat_counter2 u_sat_counter2 (
    .ctr_i (ctr_q[u_idx]),
    .inc_i (bp.actual_result),
    .dec_i (!bp.actual_result),
    .ctr_o (u_ctr_next)
  );

  // Low PC bits select bytes within a word and never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.query_pc[1:0], bp.branch_pc[1:0]};

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (upd_en) begin
      stat_upd_d = stat_upd_q + 32'd1;
    end
    if (rdy_in && bp.predict_error) begin
      stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= False;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrReset;
      end
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (upd_en) begin
        if (u_hit) begin
          ctr_q[u_idx] <= u_ctr_next;
          if (bp.actual_result) begin
            target_q[u_idx] <= bp.branch_npc;
          end
        end else if (bp.actual_result) begin
          // Taken miss allocates, evicting whatever alias occupied the slot.
          valid_q[u_idx]  <= True;
          tag_q[u_idx]    <= u_tag;
          target_q[u_idx] <= bp.branch_npc;
          ctr_q[u_idx]    <= CtrAlloc;
        end
      end
      if (rdy_in) begin
        stat_upd_q <= stat_upd_d;
        stat_mis_q <= stat_mis_d;
      end
    end
  end

  assign bp.stat_updates     = stat_upd_q;
  assign bp.stat_mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected lookups/stats, a monitor compares.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  branch_predictor_if bus ();

  branch_predictor #(.INDEX_BITS(6)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bp     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string name;
    logic  taken;
    addr_t npc;
    stat_t upd;
    stat_t mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  stat_t m_upd = '0;
  stat_t m_mis = '0;

  // One cycle of stimulus: the expectation describes outputs during this cycle,
  // while the driven update/error/reset act on the next edge.
  task automatic step(input string name, input addr_t qpc,
                      input logic upd, input logic act, input addr_t bpc, input addr_t bnpc,
                      input logic err, input logic rdy, input logic rst,
                      input logic e_taken, input addr_t e_npc);
    exp_t e;
    @(posedge clk_in);
    #1;
    bus.query_pc       = qpc;
    bus.predict_update = upd;
    bus.actual_result  = act;
    bus.branch_pc      = bpc;
    bus.branch_npc     = bnpc;
    bus.predict_error  = err;
    rdy_in             = rdy;
    rst_in             = rst;
    e.name  = name;
    e.taken = e_taken;
    e.npc   = e_npc;
    e.upd   = m_upd;
    e.mis   = m_mis;
    exp_q.push_back(e);
    if (rst) begin
      m_upd = '0;
      m_mis = '0;
    end else if (rdy) begin
      if (upd) m_upd = m_upd + 32'd1;
      if (err) m_mis = m_mis + 32'd1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".taken"}, {31'd0, bus.predict_result}, {31'd0, e.taken});
      check({e.name, ".npc"}, bus.npc, e.npc);
      check({e.name, ".stat_updates"}, bus.stat_updates, e.upd);
      check({e.name, ".stat_mispredicts"}, bus.stat_mispredicts, e.mis);
    end
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.query_pc = 32'h1000;
    bus.predict_update = 1'b0;
    bus.actual_result = 1'b0;
    bus.branch_pc = '0;
    bus.branch_npc = '0;
    bus.predict_error = 1'b0;
    repeat (2) @(posedge clk_in);

    //      name          qpc           upd  act  bpc           bnpc          err  rdy  rst  taken npc
    step("reset",        32'h1000,     0,   0,   32'h0,        32'h0,        0,   1,   0,   0,   32'h1004);
    step("alloc_same",   32'h1000,     1,   1,   32'h1000,     32'h2000,     0,   1,   0,   0,   32'h1004);
    step("alloc_hit",    32'h1000,     0,   0,   32'h0,        32'h0,        0,   1,   0,   1,   32'h2000);
    step("alias_tag",    32'h1100,     0,   0,   32'h0,        32'h0,        0,   1,   0,   0,   32'h1104);
    step("nt1_ctr2",     32'h1000,     1,   0,   32'h1000,     32'h1004,     0,   1,   0,   1,   32'h2000);
    step("nt2_ctr1",     32'h1000,     1,   0,   32'h1000,     32'h1004,     0,   1,   0,   0,   32'h1004);
    step("nt3_ctr0",     32'h1000,     1,   0,   32'h1000,     32'h1004,     0,   1,   0,   0,   32'h1004);
    step("nt4_ctr0",     32'h1000,     1,   0,   32'h1000,     32'h1004,     0,   1,   0,   0,   32'h1004);
    step("tk1_ctr0",     32'h1000,     1,   1,   32'h1000,     32'h2000,     0,   1,   0,   0,   32'h1004);
    step("tk2_ctr1",     32'h1000,     1,   1,   32'h1000,     32'h2000,     0,   1,   0,   0,   32'h1004);
    step("ctr2_taken",   32'h1000,     0,   0,   32'h0,        32'h0,        0,   1,   0,   1,   32'h2000);
    step("rdy_low",      32'h1000,     1,   0,   32'h1000,     32'h1004,     1,   0,   0,   1,   32'h2000);
    step("no_bypass",    32'h1000,     1,   1,   32'h1000,     32'h3000,     0,   1,   0,   1,   32'h2000);
    step("err_only",     32'h1000,     0,   0,   32'h0,        32'h0,        1,   1,   0,   1,   32'h3000);
    step("upd_err",      32'h2008,     1,   1,   32'h2008,     32'h4000,     1,   1,   0,   0,   32'h200c);
    step("second_ent",   32'h2008,     0,   0,   32'h0,        32'h0,        0,   1,   0,   1,   32'h4000);
    step("npc_wrap",     32'hFFFFFFFC, 0,   0,   32'h0,        32'h0,        0,   1,   0,   0,   32'h0);

    // Preload the update counter to its maximum so the next accepted update wraps it.
    @(posedge clk_in);
    #1;
    force dut.stat_upd_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_upd_q;
    m_upd = 32'hFFFF_FFFF;
    step("stat_max",     32'h3000,     1,   0,   32'h3000,     32'h3004,     0,   1,   0,   0,   32'h3004);
    step("stat_wrap",    32'h1000,     0,   0,   32'h0,        32'h0,        0,   1,   0,   1,   32'h3000);
    step("rst_vs_upd",   32'h1100,     1,   1,   32'h1100,     32'h5000,     0,   1,   1,   0,   32'h1104);
    step("post_rst_a",   32'h1100,     0,   0,   32'h0,        32'h0,        0,   1,   0,   0,   32'h1104);
    step("post_rst_b",   32'h1000,     0,   0,   32'h0,        32'h0,        0,   1,   0,   0,   32'h1004);
    step("post_rst_c",   32'h2008,     1,   1,   32'h1000,     32'h2000,     0,   1,   0,   0,   32'h200c);
    step("evict_upd",    32'h1000,     1,   1,   32'h1100,     32'h6000,     0,   1,   0,   1,   32'h2000);
    step("evicted",      32'h1000,     0,   0,   32'h0,        32'h0,        0,   1,   0,   0,   32'h1004);
    step("evictor",      32'h1100,     1,   0,   32'h1000,     32'h1004,     0,   1,   0,   1,   32'h6000);
    step("nt_no_evict",  32'h1100,     0,   0,   32'h0,        32'h0,        0,   1,   0,   1,   32'h6000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters. Sits beside the IF stage: IF presents the current fetch PC and gets a taken/not-taken guess plus the predicted next PC, both combinational. EX reports resolved control-flow outcomes back on `predict_update` / `actual_result` / `branch_pc` / `branch_npc`, which train the table on the clock edge. The block also keeps wrap-around counters of resolved branches and mispredictions for performance debug.

## Interface
- `INDEX_BITS`, 6: table has 2^INDEX_BITS entries, indexed by `pc[INDEX_BITS+1:2]`.
- `clk_in` input 1: clock.
- `rst_in` input 1: reset; synchronous, active-high.
- `rdy_in` input 1: global ready; when low, no state changes.
- `query_pc` input 32: IF fetch PC.
- `predict_result` output 1: predicted taken.
- `npc` output 32: predicted next PC.
- `predict_update` input 1: EX resolved a branch or jump this cycle.
- `actual_result` input 1: resolved taken.
- `branch_pc` input 32: PC of the resolved instruction.
- `branch_npc` input 32: resolved next PC, equal to the target when taken.
- `predict_error` input 1: EX flagged a misprediction this cycle.
- `stat_updates` output 32: count of accepted updates.
- `stat_mispredicts` output 32: count of accepted mispredictions.

## Operation
- Each entry holds `valid` (1 bit), `tag` = `pc[31:INDEX_BITS+2]`, `target` (32 bits) and `ctr` (2 bits).
- Lookup, combinational:
  - `hit = valid && tag == query_pc[31:INDEX_BITS+2]`.
  - `predict_result = hit && ctr[1]`.
  - `npc = predict_result ? target : query_pc + 4` (32-bit wrap).
- Update, on the edge when `rdy_in && predict_update`; index and tag come from `branch_pc`:
  - Hit, taken: `ctr` saturating increment (max 3); `target <= branch_npc`.
  - Hit, not taken: `ctr` saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate or replace the entry: `valid <= 1`, write the tag, `target <= branch_npc`, `ctr <= 2`.
  - Miss, not taken: no change.
- Statistics:
  - `stat_updates` increments on each accepted update.
  - `stat_mispredicts` increments when `rdy_in && predict_error`; this is independent of `predict_update`, because EX can flag an error with no update.
  - Both counters wrap from 0xFFFFFFFF to 0.
- `rdy_in` low: table and counters hold; lookup outputs remain valid.

## Timing
- Lookup latency: 0 cycles.
- Update takes effect on the next edge and is visible to lookups from the following cycle.
- Simultaneous update and lookup of the same index: the lookup returns the pre-update contents; there is no bypass.
- Reset (synchronous, `rst_in` high at the edge): all `valid` = 0, all `ctr` = 1, tags and targets = 0, both stat counters = 0.
  - Reset has priority over a concurrent update.
  - After the reset edge, `predict_result` = 0 and `npc = query_pc + 4` for every PC.
- Reset asserted mid-stream discards all training; there is no partial state.
- Aliasing: two PCs with the same index but different tags evict each other only on a taken resolution.

## Structure
- Table and stat widths come from the shared `config.v` macros: `InstAddrBus`, `RegBus`, `True`/`False`; add `BtbIndexBits` there as the default for `INDEX_BITS`.
- Natural sub-module: `sat_counter2`, a pure function of old value and `inc`/`dec` giving the next 2-bit value. It is instantiated once on the update path.
- Table storage is plain register arrays, so there is no memory macro and reset clears all entries in one cycle.

## Test plan
- Reset, then query `0x1000` → `predict_result` = 0, `npc` = `0x1004`; both stats = 0.
- Update `pc=0x1000`, taken, `npc=0x2000`; next cycle query `0x1000` → taken, `npc` = `0x2000` (`ctr` = 2). Query `0x1100` (same index, different tag) → not taken, `npc` = `0x1104`.
- Four not-taken updates at `0x1000` → `ctr` 2→1→0→0; query gives `npc` = `0x1004`. Then one taken update → `ctr` = 1, still predicts not taken; a second taken update → predicts taken.
- Update and query of `0x1000` in the same cycle with `rdy_in` = 1 → the query sees old contents. With `rdy_in` = 0 an update is ignored and `stat_updates` is unchanged.
- Three updates plus two `predict_error` pulses (one with no update) → `stat_updates` = 3, `stat_mispredicts` = 2. Preload `stat_updates` to 0xFFFFFFFF via repeated updates or a force, then update once → 0.
- `rst_in` asserted in the same cycle as a taken update → the entry stays invalid and the stats are 0.
